// File: rtl/retire_monitor.sv
// Commit-stream observer for the beaver32rv core: performance counters, a write-back
// signature, and a sticky halt flag with its cause and PC once the program stops.
module retire_monitor #(
  parameter int XLEN         = 32,
  parameter int CNT_W        = 32,
  parameter int LOOP_THRESH  = 4,
  parameter int MAX_CYCLES   = 1500,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [XLEN-1:0]  pc_addr,
  input  logic [XLEN-1:0]  next_address,
  input  logic [31:0]      instruction,
  input  logic             reg_write,
  input  logic [4:0]       rd,
  input  logic [XLEN-1:0]  write_data,
  input  logic             mem_write,
  input  logic             branch_taken,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [XLEN-1:0]  halt_pc,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count,
  output logic [CNT_W-1:0] store_count,
  output logic [CNT_W-1:0] taken_count,
  output logic [31:0]      signature
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_SYSTEM  = 2'd1,
    CAUSE_LOOP    = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } cause_t;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  localparam int LOOP_W  = 8;
  localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [LOOP_W-1:0]  LOOP_LIMIT = LOOP_W'(LOOP_THRESH);
  localparam logic [CNT_W-1:0]   CYCLE_LIMIT = CNT_W'(MAX_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST =
    DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  state_t              state;
  logic [LOOP_W-1:0]   loop_cnt;
  logic [DRAIN_W-1:0]  drain_cnt;

  logic [LOOP_W-1:0]   loop_next;
  logic [CNT_W-1:0]    cycle_next;
  logic [31:0]         sig_next;
  cause_t              cause_next;

  // Counters stick at all-ones rather than wrapping, so a long run never reads as short.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + 1'b1 : v;
  endfunction

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    loop_next  = '0;
    cycle_next = sat_inc(cycle_count, 1'b1);
    sig_next   = signature;
    cause_next = CAUSE_NONE;

    if (next_address == pc_addr)
      loop_next = (loop_cnt >= LOOP_LIMIT) ? LOOP_LIMIT : loop_cnt + 1'b1;

    if (reg_write && (rd != 5'd0))
      sig_next = {signature[30:0], signature[31]} ^ write_data[31:0] ^ {27'b0, rd};

    if ((instruction == ECALL) || (instruction == EBREAK))
      cause_next = CAUSE_SYSTEM;
    else if (loop_next == LOOP_LIMIT)
      cause_next = CAUSE_LOOP;
    else if (cycle_next == CYCLE_LIMIT)
      cause_next = CAUSE_TIMEOUT;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      loop_cnt      <= '0;
      drain_cnt     <= '0;
      halted        <= 1'b0;
      halt_cause    <= CAUSE_NONE;
      halt_pc       <= '0;
      cycle_count   <= '0;
      retired_count <= '0;
      store_count   <= '0;
      taken_count   <= '0;
      signature     <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (en) begin
            cycle_count   <= cycle_next;
            retired_count <= sat_inc(retired_count, 1'b1);
            store_count   <= sat_inc(store_count, mem_write);
            taken_count   <= sat_inc(taken_count, branch_taken);
            signature     <= sig_next;
            loop_cnt      <= loop_next;
            // The triggering instruction is still fully accounted for above.
            if (cause_next != CAUSE_NONE) begin
              halt_pc    <= pc_addr;
              halt_cause <= cause_next;
              drain_cnt  <= '0;
              if (DRAIN_CYCLES == 0) begin
                state  <= HALTED;
                halted <= 1'b1;
              end else begin
                state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_retire_monitor.sv
// Directed bench for retire_monitor: counters, signature, each halt cause, drain timing
// and reset out of DRAIN/HALTED, against hand-derived expectations.
module tb_retire_monitor;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] JAL0   = 32'h0000_006f;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [31:0] pc_addr = '0;
  logic [31:0] next_address = '0;
  logic [31:0] instruction = '0;
  logic        reg_write = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] write_data = '0;
  logic        mem_write = 1'b0;
  logic        branch_taken = 1'b0;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] halt_pc;
  logic [31:0] cycle_count;
  logic [31:0] retired_count;
  logic [31:0] store_count;
  logic [31:0] taken_count;
  logic [31:0] signature;

  int checks = 0;
  int errors = 0;

  retire_monitor #(
    .XLEN(32), .CNT_W(32), .LOOP_THRESH(4), .MAX_CYCLES(20), .DRAIN_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pc_addr(pc_addr), .next_address(next_address),
    .instruction(instruction), .reg_write(reg_write), .rd(rd), .write_data(write_data),
    .mem_write(mem_write), .branch_taken(branch_taken), .halted(halted),
    .halt_cause(halt_cause), .halt_pc(halt_pc), .cycle_count(cycle_count),
    .retired_count(retired_count), .store_count(store_count), .taken_count(taken_count),
    .signature(signature)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sig_fold(input logic [31:0] s, input logic [31:0] wd,
                                           input logic [4:0] r);
    return {s[30:0], s[31]} ^ wd ^ {27'b0, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [31:0] pc, input logic [31:0] nxt,
                       input logic [31:0] ins, input logic rw, input logic [4:0] r,
                       input logic [31:0] wd, input logic mw, input logic bt);
    en = e; pc_addr = pc; next_address = nxt; instruction = ins;
    reg_write = rw; rd = r; write_data = wd; mem_write = mw; branch_taken = bt;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 32'h4, NOP, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h100, 32'h100, ECALL, 1'b1, 5'd7, 32'hdead_beef, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({halted, halt_cause, halt_pc, cycle_count, retired_count, store_count,
         taken_count, signature} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: halted=%b cause=%0d pc=%h cyc=%0d ret=%0d st=%0d tk=%0d sig=%h, expected all zero",
               halted, halt_cause, halt_pc, cycle_count, retired_count, store_count,
               taken_count, signature);
    end
  endtask

  task automatic test_signature();
    logic [31:0] exp_sig = '0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(4 * i), 32'(4 * i + 4), NOP, 1'b1, 5'd5, 32'd1, 1'b0, 1'b0);
      tick();
      exp_sig = sig_fold(exp_sig, 32'd1, 5'd5);
    end
    drive(1'b0, 32'h0, 32'h4, NOP, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (cycle_count !== 32'd10) begin
      errors++; $display("FAIL sig_cycle_count: got %0d expected 10", cycle_count);
    end
    checks++;
    if (retired_count !== 32'd10) begin
      errors++; $display("FAIL sig_retired_count: got %0d expected 10", retired_count);
    end
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL sig_halted: got %b expected 0", halted);
    end
    checks++;
    if (signature !== exp_sig) begin
      errors++; $display("FAIL sig_value: got %h expected %h", signature, exp_sig);
    end
  endtask

  task automatic test_x0_write();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(4 * i), 32'(4 * i + 4), NOP, 1'b1, 5'd0, 32'd1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h4, NOP, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (signature !== 32'h0) begin
      errors++; $display("FAIL x0_signature: got %h expected 00000000", signature);
    end
    checks++;
    if (cycle_count !== 32'd10 || retired_count !== 32'd10) begin
      errors++;
      $display("FAIL x0_counters: got cyc=%0d ret=%0d expected 10/10", cycle_count, retired_count);
    end
  endtask

  // ECALL lands on the same cycle the self-loop counter reaches 4: cause 1 must win.
  task automatic test_ecall_priority();
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      if (i <= 3)
        drive(1'b1, 32'(4 * (i - 1)), 32'(4 * i), NOP, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      else
        drive(1'b1, 32'h40, 32'h40, (i == 7) ? ECALL : NOP, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h80, 32'h84, NOP, 1'b1, 5'd9, 32'h55, 1'b1, 1'b1);
    checks++;
    if (halt_cause !== 2'd1 || halt_pc !== 32'h40 || retired_count !== 32'd7) begin
      errors++;
      $display("FAIL ecall_trigger: got cause=%0d pc=%h ret=%0d expected 1/00000040/7",
               halt_cause, halt_pc, retired_count);
    end
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL ecall_halted_at_trigger: got %b expected 0", halted);
    end
    tick();
    checks++;
    if (halted !== 1'b0 || retired_count !== 32'd7) begin
      errors++;
      $display("FAIL ecall_drain1: got halted=%b ret=%0d expected 0/7", halted, retired_count);
    end
    tick();
    checks++;
    if (halted !== 1'b1) begin
      errors++; $display("FAIL ecall_drain2: got halted=%b expected 1", halted);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (halted !== 1'b1 || halt_cause !== 2'd1 || retired_count !== 32'd7 ||
          signature !== 32'h0) begin
        errors++;
        $display("FAIL ecall_sticky[%0d]: got halted=%b cause=%0d ret=%0d sig=%h expected 1/1/7/0",
                 i, halted, halt_cause, retired_count, signature);
      end
    end
  endtask

  task automatic test_ebreak();
    do_reset();
    drive(1'b1, 32'h100, 32'h104, EBREAK, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h4, NOP, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (halt_cause !== 2'd1 || halt_pc !== 32'h100 || retired_count !== 32'd1 ||
        store_count !== 32'd1) begin
      errors++;
      $display("FAIL ebreak_trigger: got cause=%0d pc=%h ret=%0d st=%0d expected 1/00000100/1/1",
               halt_cause, halt_pc, retired_count, store_count);
    end
  endtask

  // Cycles 1..9; is_loop[c] marks cycles spent on 'jal x0,0' at 0x20.
  task automatic run_loop(input logic [9:1] is_loop, input int trig);
    for (int c = 1; c <= trig; c++) begin
      if (is_loop[c])
        drive(1'b1, 32'h20, 32'h20, JAL0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      else
        drive(1'b1, 32'(4 * c + 32'h100), 32'(4 * c + 32'h104), NOP, 1'b0, 5'd0, 32'h0,
              1'b0, 1'b0);
      tick();
      if (c == trig - 1) begin
        checks++;
        if (halt_cause !== 2'd0) begin
          errors++;
          $display("FAIL loop_early_c%0d: got cause=%0d expected 0", c, halt_cause);
        end
      end
    end
    drive(1'b0, 32'h0, 32'h4, NOP, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (halt_cause !== 2'd2 || halt_pc !== 32'h20 || retired_count !== 32'(trig)) begin
      errors++;
      $display("FAIL loop_trigger_c%0d: got cause=%0d pc=%h ret=%0d expected 2/00000020/%0d",
               trig, halt_cause, halt_pc, retired_count, trig);
    end
  endtask

  task automatic test_self_loop();
    do_reset();
    run_loop(9'b1_1111_1100, 6);
    do_reset();
    run_loop(9'b1_1110_1100, 9);
  endtask

  task automatic test_timeout();
    int          exp_cyc = 0;
    int          exp_st  = 0;
    int          exp_tk  = 0;
    logic [31:0] exp_sig = '0;
    logic        e, mw, bt;
    do_reset();
    for (int k = 0; k < 25; k++) begin
      e  = !(k >= 10 && k < 15);
      mw = (k % 3 == 0);
      bt = (k % 4 == 1);
      drive(e, 32'(4 * k), 32'(4 * k + 4), NOP, 1'b1, 5'd3, 32'(k), mw, bt);
      tick();
      if (e) begin
        exp_cyc++;
        exp_st += int'(mw);
        exp_tk += int'(bt);
        exp_sig = sig_fold(exp_sig, 32'(k), 5'd3);
      end
      if (k == 14) begin
        checks++;
        if (cycle_count !== 32'd10 || signature !== exp_sig) begin
          errors++;
          $display("FAIL timeout_en_hold: got cyc=%0d sig=%h expected 10/%h",
                   cycle_count, signature, exp_sig);
        end
      end
      if (k == 23) begin
        checks++;
        if (halt_cause !== 2'd0 || cycle_count !== 32'd19) begin
          errors++;
          $display("FAIL timeout_early: got cause=%0d cyc=%0d expected 0/19", halt_cause, cycle_count);
        end
      end
    end
    drive(1'b0, 32'h0, 32'h4, NOP, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (halt_cause !== 2'd3 || halt_pc !== 32'h60 || cycle_count !== 32'd20) begin
      errors++;
      $display("FAIL timeout_trigger: got cause=%0d pc=%h cyc=%0d expected 3/00000060/20",
               halt_cause, halt_pc, cycle_count);
    end
    checks++;
    if (store_count !== 32'(exp_st) || taken_count !== 32'(exp_tk) ||
        signature !== exp_sig) begin
      errors++;
      $display("FAIL timeout_counts: got st=%0d tk=%0d sig=%h expected %0d/%0d/%h",
               store_count, taken_count, signature, exp_st, exp_tk, exp_sig);
    end
    tick();
    tick();
    checks++;
    if (halted !== 1'b1) begin
      errors++; $display("FAIL timeout_halted: got %b expected 1", halted);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 32'h200, 32'h204, EBREAK, 1'b1, 5'd2, 32'h7, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h4, NOP, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({halted, halt_cause, halt_pc, cycle_count, retired_count, store_count,
         taken_count, signature} !== '0) begin
      errors++;
      $display("FAIL rst_in_drain: got halted=%b cause=%0d pc=%h cyc=%0d sig=%h expected all zero",
               halted, halt_cause, halt_pc, cycle_count, signature);
    end
    tick(); tick(); tick();
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL rst_in_drain_no_halt: got %b expected 0", halted);
    end
    drive(1'b1, 32'h300, 32'h304, NOP, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    checks++;
    if (cycle_count !== 32'd1 || retired_count !== 32'd1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_drain_restart: got cyc=%0d ret=%0d halted=%b expected 1/1/0",
               cycle_count, retired_count, halted);
    end

    drive(1'b1, 32'h304, 32'h308, ECALL, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h4, NOP, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick(); tick();
    checks++;
    if (halted !== 1'b1 || halt_pc !== 32'h304) begin
      errors++;
      $display("FAIL rst_reach_halted: got halted=%b pc=%h expected 1/00000304", halted, halt_pc);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({halted, halt_cause, halt_pc, cycle_count, retired_count, store_count,
         taken_count, signature} !== '0) begin
      errors++;
      $display("FAIL rst_in_halted: got halted=%b cause=%0d pc=%h cyc=%0d expected all zero",
               halted, halt_cause, halt_pc, cycle_count);
    end
    drive(1'b1, 32'h400, 32'h404, NOP, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    checks++;
    if (cycle_count !== 32'd1 || retired_count !== 32'd1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_halted_restart: got cyc=%0d ret=%0d halted=%b expected 1/1/0",
               cycle_count, retired_count, halted);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_signature();
    test_x0_write();
    test_ecall_priority();
    test_ebreak();
    test_self_loop();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
